// File: rtl/spi_ram_master_if.sv
// Host-side command handshake plus the SPI pins of the SPI-slave/RAM subsystem.
interface spi_ram_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       sclk;
  logic       mosi;
  logic       ss_n;
  logic       miso;

  modport master (
    input  start, cmd, wdata, miso,
    output busy, done, rdata, rdata_valid, sclk, mosi, ss_n
  );

  modport slave (
    output start, cmd, wdata, miso,
    input  busy, done, rdata, rdata_valid, sclk, mosi, ss_n
  );
endinterface

// File: rtl/spi_ram_master.sv
// SPI mode-0 master: sends a 10-bit {cmd, byte} frame, and on read-data runs a
// turnaround and captures an 8-bit MISO reply.
module spi_ram_master #(
  parameter int CLK_DIV      = 2,
  parameter int TURN_CYCLES  = 1,
  parameter int GUARD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  spi_ram_master_if.master  bus
);

  localparam int NMAX = 18 + TURN_CYCLES;
  localparam int PW   = $clog2(NMAX + 1);
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW   = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GRD_LAST  = GW'(GUARD_CYCLES - 1);
  localparam logic [PW-1:0] P_WR      = PW'(10);
  localparam logic [PW-1:0] P_RD      = PW'(NMAX);
  localparam logic [PW-1:0] P_WR_LAST = PW'(9);
  localparam logic [PW-1:0] P_TN_LAST = PW'(9 + TURN_CYCLES);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TURN, RECV, GUARD} state_t;

  state_t        state;
  logic [8:0]    shreg;
  logic          is_rd;
  logic [DW-1:0] div_cnt;
  logic [PW-1:0] per_cnt;
  logic [GW-1:0] grd_cnt;
  logic [7:0]    rx_sh;

  // per_cnt counts completed sclk periods over the whole frame; the frame ends
  // one low half-period after the last falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bus.ss_n        <= 1'b1;
      bus.sclk        <= 1'b0;
      bus.mosi        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
      shreg           <= '0;
      is_rd           <= 1'b0;
      div_cnt         <= '0;
      per_cnt         <= '0;
      grd_cnt         <= '0;
      rx_sh           <= '0;
    end else begin
      bus.done        <= 1'b0;
      bus.rdata_valid <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          shreg    <= {bus.cmd[0], (bus.cmd == 2'b11) ? 8'h00 : bus.wdata};
          is_rd    <= (bus.cmd == 2'b11);
          bus.mosi <= bus.cmd[1];
          bus.ss_n <= 1'b0;
          bus.busy <= 1'b1;
          div_cnt  <= '0;
          per_cnt  <= '0;
          state    <= SETUP;
        end
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            bus.sclk <= 1'b1;
            state    <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT, TURN, RECV: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!bus.sclk) begin
              if (per_cnt == (is_rd ? P_RD : P_WR)) begin
                bus.ss_n <= 1'b1;
                bus.mosi <= 1'b0;
                grd_cnt  <= '0;
                state    <= GUARD;
              end else begin
                bus.sclk <= 1'b1;
                if (state == RECV) rx_sh <= {rx_sh[6:0], bus.miso};
              end
            end else begin
              bus.sclk <= 1'b0;
              per_cnt  <= per_cnt + 1'b1;
              shreg    <= {shreg[7:0], 1'b0};
              bus.mosi <= (state == SHIFT && per_cnt < P_WR_LAST) ? shreg[8] : 1'b0;
              if (state == SHIFT && per_cnt == P_WR_LAST && is_rd)
                state <= (TURN_CYCLES > 0) ? TURN : RECV;
              if (state == TURN && per_cnt == P_TN_LAST)
                state <= RECV;
            end
          end
        end
        GUARD: begin
          if (grd_cnt == GRD_LAST) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            if (is_rd) begin
              bus.rdata       <= rx_sh;
              bus.rdata_valid <= 1'b1;
            end
          end else begin
            grd_cnt <= grd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed and randomized frames on two masters (CLK_DIV=2 and CLK_DIV=1) checked against a frame-level model.
module tb_spi_ram_master;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_ram_master_if b0();
  spi_ram_master_if b1();

  spi_ram_master #(.CLK_DIV(2), .TURN_CYCLES(1), .GUARD_CYCLES(4)) u0 (.clk(clk), .reset(reset), .bus(b0));
  spi_ram_master #(.CLK_DIV(1), .TURN_CYCLES(1), .GUARD_CYCLES(4)) u1 (.clk(clk), .reset(reset), .bus(b1));

  logic       sel;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] wdata;
  logic       miso;

  assign b0.start = start & ~sel;
  assign b1.start = start & sel;
  assign b0.cmd   = cmd;
  assign b1.cmd   = cmd;
  assign b0.wdata = wdata;
  assign b1.wdata = wdata;
  assign b0.miso  = miso;
  assign b1.miso  = miso;

  logic       ss_m, sclk_m, mosi_m, bz_m, done_m, rv_m;
  logic [7:0] rd_m;
  assign ss_m   = sel ? b1.ss_n        : b0.ss_n;
  assign sclk_m = sel ? b1.sclk        : b0.sclk;
  assign mosi_m = sel ? b1.mosi        : b0.mosi;
  assign bz_m   = sel ? b1.busy        : b0.busy;
  assign done_m = sel ? b1.done        : b0.done;
  assign rv_m   = sel ? b1.rdata_valid : b0.rdata_valid;
  assign rd_m   = sel ? b1.rdata       : b0.rdata;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int first_low_g, last_rise_g;
  logic [7:0] exp_rd [2];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Runs one frame from acceptance to done and checks it against the frame model.
  task automatic frame(input logic s, input logic [1:0] c, input logic [7:0] w,
                       input logic [7:0] sb, input bit keep, input bit inj);
    int cd, n, lowcnt, rises, falls, rise_k, done_k, last_k;
    bit iv_ok, mosi_ok;
    logic p_sclk, p_ss, rv, bz;
    logic [7:0] rd;
    logic [9:0] bits;
    cd = s ? 1 : 2;
    n  = (c == 2'b11) ? 19 : 10;
    bits = {c, (c == 2'b11) ? 8'h00 : w};
    lowcnt = 0; rises = 0; falls = 0; rise_k = -1; done_k = -1; last_k = 0;
    iv_ok = 1; mosi_ok = 1; p_sclk = 0; p_ss = 1; rv = 0; bz = 1; rd = 0;
    sel = s; start = 1; cmd = c; wdata = w; miso = 0;
    for (int k = 1; k <= 400 && done_k < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("busy_after_accept", bz_m, 1);
        chk("ss_low_after_accept", ss_m, 0);
        first_low_g = cyc;
        if (!keep) start = 0;
      end
      if (inj && k == 20) begin start = 1; cmd = 2'b01; wdata = 8'hA5; end
      if (inj && k == 21) start = 0;
      if (!ss_m) lowcnt++;
      if (sclk_m && !p_sclk) begin
        if (rises < 10) begin
          if (mosi_m !== bits[9-rises]) mosi_ok = 0;
        end else if (mosi_m !== 1'b0) mosi_ok = 0;
        if (rises > 0 && (k - last_k) != 2*cd) iv_ok = 0;
        last_k = k;
        rises++;
      end
      if (!sclk_m && p_sclk) begin
        falls++;
        if (c == 2'b11 && falls >= 11 && falls < 19) miso = sb[7-(falls-11)];
        else miso = 0;
      end
      if (ss_m && !p_ss) begin rise_k = k; last_rise_g = cyc; end
      if (done_m) begin done_k = k; rv = rv_m; rd = rd_m; bz = bz_m; end
      p_sclk = sclk_m;
      p_ss   = ss_m;
    end
    if (c == 2'b11) exp_rd[s] = sb;
    chk("done_seen", done_k > 0, 1);
    chk("ss_low_len", lowcnt, (1 + 2*n) * cd);
    chk("sclk_rises", rises, n);
    chk("mosi_bits", mosi_ok, 1);
    chk("sclk_period", iv_ok, 1);
    chk("done_after_ss_rise", done_k - rise_k, 4);
    chk("rdata_valid", rv, (c == 2'b11));
    chk("rdata", rd, exp_rd[s]);
    chk("busy_at_done", bz, 0);
  endtask

  task automatic quiet(input int n, input string tag);
    int dn, lo;
    dn = 0; lo = 0;
    repeat (n) begin
      @(negedge clk);
      if (done_m) dn++;
      if (!ss_m) lo++;
    end
    chk({tag, "_no_done"}, dn, 0);
    chk({tag, "_ss_high"}, lo, 0);
  endtask

  initial begin
    int r1, rs;
    logic ps;
    logic s;
    logic [1:0] c;
    logic [7:0] w, sb;
    sel = 0; start = 0; cmd = 0; wdata = 0; miso = 0; reset = 1;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", b0.ss_n, 1);
    chk("rst_sclk", b0.sclk, 0);
    chk("rst_mosi", b0.mosi, 0);
    chk("rst_busy", b0.busy, 0);
    chk("rst_done", b0.done, 0);
    chk("rst_rdata", b0.rdata, 0);
    chk("rst_rvalid", b0.rdata_valid, 0);
    chk("rst_ss_n_div1", b1.ss_n, 1);
    reset = 0;
    @(negedge clk);

    frame(0, 2'b00, 8'h5A, 8'h00, 0, 0);
    frame(0, 2'b11, 8'h77, 8'hC3, 0, 0);
    frame(0, 2'b01, 8'h3C, 8'h00, 0, 1);
    quiet(150, "reject");

    frame(0, 2'b00, 8'h81, 8'h00, 1, 0);
    r1 = last_rise_g;
    frame(0, 2'b01, 8'h42, 8'h00, 0, 0);
    chk("b2b_gap_ge5", (first_low_g - r1) >= 5, 1);
    quiet(10, "b2b_tail");

    sel = 0; start = 1; cmd = 2'b00; wdata = 8'h99;
    @(negedge clk);
    start = 0;
    rs = 0; ps = 0;
    for (int k = 0; k < 200 && rs < 5; k++) begin
      @(negedge clk);
      if (sclk_m && !ps) rs++;
      ps = sclk_m;
    end
    chk("rst_reach_bit5", rs, 5);
    reset = 1;
    @(negedge clk);
    chk("midrst_ss_n", b0.ss_n, 1);
    chk("midrst_sclk", b0.sclk, 0);
    chk("midrst_busy", b0.busy, 0);
    chk("midrst_done", b0.done, 0);
    reset = 0;
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
    quiet(60, "post_reset");
    frame(0, 2'b10, 8'hFF, 8'h00, 0, 0);

    frame(1, 2'b01, 8'h00, 8'h00, 0, 0);
    frame(1, 2'b11, 8'h00, 8'h96, 0, 0);

    for (int i = 0; i < 8; i++) begin
      s  = 1'($urandom_range(0, 1));
      c  = 2'($urandom_range(0, 3));
      w  = 8'($urandom_range(0, 255));
      sb = 8'($urandom_range(0, 255));
      frame(s, c, w, sb, 0, 0);
    end
    quiet(8, "final");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
